si570_write_sequencer: RTL and testbench
========================================

Name: si570_write_sequencer

Overview:
- Sits directly downstream of the push-button edge detector/debouncer in the Si570 controller.
- Consumes the debounced one-cycle trigger pulse.
- Runs the Si570 frequency-change register sequence (freeze DCO, write RFREQ/HS_DIV/N1 bytes, unfreeze, NewFreq) through a byte-write I2C master, then waits for the output clock to settle.
- Reports busy, done and error status to the top-level controller.

Parameters:
- I2C_DEV_ADDR, 7'h55, Si570 7-bit I2C address driven on oI2C_ADDR.
- SETTLE_CYCLES, 500000, iCLK cycles to wait after NewFreq before signalling done (10 ms at 50 MHz); minimum 1.
- TIMEOUT_CYCLES, 100000, maximum iCLK cycles a single write may stay outstanding before it is treated as an error.
- CNT_W, 20, width of the shared settle/timeout counter; must hold max(SETTLE_CYCLES, TIMEOUT_CYCLES).

Ports:
- iCLK  in  1  system clock
- iRST_n  in  1  asynchronous active-low reset
- iSTART  in  1  one-cycle trigger from the debouncer
- iFREQ_SEL  in  2  frequency table entry; sampled on an accepted iSTART
- oI2C_REQ  out  1  write request to the I2C master
- oI2C_ADDR  out  7  device address; constant I2C_DEV_ADDR
- oI2C_REG  out  8  register index
- oI2C_DATA  out  8  register data
- iI2C_ACK  in  1  one-cycle pulse: current write completed OK
- iI2C_ERR  in  1  one-cycle pulse: current write NACKed/failed
- oBUSY  out  1  sequence in progress
- oDONE  out  1  one-cycle pulse on successful completion
- oERROR  out  1  sticky failure flag; cleared by the next accepted iSTART

Behaviour:
- Reset values: all outputs 0 except oI2C_ADDR, which is I2C_DEV_ADDR. The FSM is in IDLE, the counter is 0 and the byte index is 0. Reset mid-sequence abandons the sequence immediately; no unfreeze write is issued.
- FSM states: IDLE, FREEZE, WR_RF, UNFREEZE, NEWFREQ, SETTLE, RECOVER.
- IDLE:
  - On iSTART: latch iFREQ_SEL, clear oERROR, set oBUSY, and enter FREEZE on the next cycle.
  - iSTART in any other state is ignored.
- Writes issued, in order:
  - FREEZE: reg 137 = 8'h10.
  - WR_RF: regs 7..12 = table[sel][0..5], with byte index 0..5.
  - UNFREEZE: reg 137 = 8'h00.
  - NEWFREQ: reg 135 = 8'h40.
  - Nine writes total.
- Handshake:
  - oI2C_REQ rises the cycle after a write state is entered.
  - oI2C_REQ, oI2C_REG and oI2C_DATA are held stable until iI2C_ACK or iI2C_ERR.
  - oI2C_REQ deasserts in the cycle after the response. It stays low for at least 1 cycle between writes.
  - A response arriving while oI2C_REQ is low is ignored.
  - If iI2C_ACK and iI2C_ERR arrive in the same cycle, ERR takes priority.
- Byte sequencing in WR_RF:
  - ACK at index < 5 increments the index and issues the next write.
  - ACK at index 5 moves to UNFREEZE.
- Timeout:
  - The counter resets to 0 when each request is issued and increments while the request is outstanding.
  - Reaching TIMEOUT_CYCLES-1 without a response is handled exactly as iI2C_ERR.
- Error handling:
  - Error in FREEZE or NEWFREQ: set oERROR and go to IDLE.
  - Error in WR_RF or UNFREEZE: set oERROR and go to RECOVER.
- RECOVER:
  - Issues one best-effort write of reg 137 = 8'h00.
  - On ACK, ERR or timeout, goes to IDLE with oERROR still set.
- SETTLE:
  - Entered after the NEWFREQ ACK; the counter starts from 0.
  - After exactly SETTLE_CYCLES cycles in SETTLE: oDONE pulses for 1 cycle, oBUSY falls in the same cycle, and the FSM returns to IDLE.
- oBUSY is high in every state except IDLE.
- Counter arithmetic is CNT_W unsigned. Wrap is impossible by construction.

Decomposition:
- Shared package si570_pkg:
  - Register constants: REG_FREEZE=137, REG_RFREQ0=7, REG_CTRL=135.
  - Data constants: FREEZE_ON=8'h10, FREEZE_OFF=8'h00, NEWFREQ=8'h40.
  - State enum.
  - 4x6-byte frequency table constant, with accessor function si570_table(sel, idx).
- No sub-module is needed; the FSM, counter and index live in one module.
- The I2C master is external.

Test Plan:
- Nominal: iSTART with iFREQ_SEL=2, and the responder ACKs each write 5 cycles after REQ. Required response:
  - Exactly 9 writes in the order 137/10, 7..12 (table[2]), 137/00, 135/40.
  - oDONE pulses SETTLE_CYCLES cycles after the last ACK.
  - oBUSY spans the whole sequence.
- NACK mid-sequence: iI2C_ERR on the 3rd RFREQ write (reg 9). Required response:
  - Next write is 137/00.
  - After it is ACKed: oERROR=1, oBUSY=0, no oDONE.
- Timeout: the responder never answers the FREEZE write. Required response: REQ held TIMEOUT_CYCLES cycles, then oERROR=1, IDLE, no further REQ.
- Ignored trigger: iSTART pulsed during WR_RF with a different iFREQ_SEL. Required response: the sequence is unchanged and data still comes from the originally latched entry.
- Same-cycle ACK+ERR on the UNFREEZE write. Required response: treated as error; the RECOVER write is issued; oERROR=1.
- Async reset asserted during SETTLE. Required response: all outputs are at reset values immediately; a new iSTART afterwards runs a full clean sequence.

Source files
------------

// File: rtl/si570_pkg.sv
// Shared constants, FSM state type and frequency table for the Si570 write sequencer.
package si570_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FREEZE,
    S_WR_RF,
    S_UNFREEZE,
    S_NEWFREQ,
    S_SETTLE,
    S_RECOVER
  } state_e;

  localparam logic [7:0] REG_FREEZE = 8'd137;
  localparam logic [7:0] REG_RFREQ0 = 8'd7;
  localparam logic [7:0] REG_CTRL   = 8'd135;

  localparam logic [7:0] FREEZE_ON  = 8'h10;
  localparam logic [7:0] FREEZE_OFF = 8'h00;
  localparam logic [7:0] NEWFREQ    = 8'h40;

  localparam int unsigned RF_BYTES = 6;

  // Row byte 0 (MSB) goes to register 7, byte 5 (LSB) to register 12.
  function automatic logic [7:0] si570_table(input logic [1:0] sel, input logic [2:0] idx);
    logic [47:0] row;
    logic [7:0]  b;
    case (sel)
      2'd0:    row = 48'h01_C2_BC_01_1E_B8;
      2'd1:    row = 48'hE0_42_B0_2B_1B_54;
      2'd2:    row = 48'h22_42_D6_8A_B7_5F;
      default: row = 48'h61_C2_A8_74_8F_E6;
    endcase
    case (idx)
      3'd0:    b = row[47:40];
      3'd1:    b = row[39:32];
      3'd2:    b = row[31:24];
      3'd3:    b = row[23:16];
      3'd4:    b = row[15:8];
      3'd5:    b = row[7:0];
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/si570_write_sequencer.sv
// Runs the Si570 freeze / RFREQ / unfreeze / NewFreq write sequence over a
// byte-write I2C master, then waits for the output clock to settle.
module si570_write_sequencer
  import si570_pkg::*;
#(
  parameter logic [6:0]  I2C_DEV_ADDR   = 7'h55,
  parameter int unsigned SETTLE_CYCLES  = 500000,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic       iSTART,
  input  logic [1:0] iFREQ_SEL,
  output logic       oI2C_REQ,
  output logic [6:0] oI2C_ADDR,
  output logic [7:0] oI2C_REG,
  output logic [7:0] oI2C_DATA,
  input  logic       iI2C_ACK,
  input  logic       iI2C_ERR,
  output logic       oBUSY,
  output logic       oDONE,
  output logic       oERROR
);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [1:0]       sel_q, sel_d;
  logic             req_q, req_d;
  logic [7:0]       reg_q, reg_d;
  logic [7:0]       data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             is_write;
  logic [7:0]       wr_reg, wr_data;
  logic             rsp_ok, rsp_fail;

  always_comb begin
    wr_reg  = REG_FREEZE;
    wr_data = FREEZE_OFF;
    case (state_q)
      S_FREEZE: wr_data = FREEZE_ON;
      S_WR_RF: begin
        wr_reg  = REG_RFREQ0 + {5'd0, idx_q};
        wr_data = si570_table(sel_q, idx_q);
      end
      S_NEWFREQ: begin
        wr_reg  = REG_CTRL;
        wr_data = NEWFREQ;
      end
      default: ;
    endcase
  end

  assign is_write = (state_q == S_FREEZE) || (state_q == S_WR_RF) ||
                    (state_q == S_UNFREEZE) || (state_q == S_NEWFREQ) ||
                    (state_q == S_RECOVER);

  // ERR beats a same-cycle ACK; a late ACK on the final timeout cycle still counts.
  assign rsp_fail = req_q && (iI2C_ERR || (!iI2C_ACK && cnt_q == TO_LAST));
  assign rsp_ok   = req_q && iI2C_ACK && !iI2C_ERR;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    req_d   = req_q;
    reg_d   = reg_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;

    if (state_q == S_IDLE) begin
      if (iSTART) begin
        sel_d   = iFREQ_SEL;
        err_d   = 1'b0;
        busy_d  = 1'b1;
        idx_d   = '0;
        state_d = S_FREEZE;
      end
    end else if (state_q == S_SETTLE) begin
      if (cnt_q == SET_LAST) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (is_write) begin
      // Entering a write state leaves REQ low for one cycle, then the request is issued.
      if (!req_q) begin
        req_d  = 1'b1;
        cnt_d  = '0;
        reg_d  = wr_reg;
        data_d = wr_data;
      end else if (rsp_fail) begin
        req_d = 1'b0;
        err_d = 1'b1;
        if (state_q == S_WR_RF || state_q == S_UNFREEZE) begin
          state_d = S_RECOVER;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end else if (rsp_ok) begin
        req_d = 1'b0;
        case (state_q)
          S_FREEZE: state_d = S_WR_RF;
          S_WR_RF: begin
            if (idx_q == 3'(RF_BYTES - 1)) state_d = S_UNFREEZE;
            else                           idx_d   = idx_q + 1'b1;
          end
          S_UNFREEZE: state_d = S_NEWFREQ;
          S_NEWFREQ: begin
            cnt_d   = '0;
            state_d = S_SETTLE;
          end
          default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      req_q   <= 1'b0;
      reg_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      req_q   <= req_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign oI2C_REQ  = req_q;
  assign oI2C_ADDR = I2C_DEV_ADDR;
  assign oI2C_REG  = reg_q;
  assign oI2C_DATA = data_q;
  assign oBUSY     = busy_q;
  assign oDONE     = done_q;
  assign oERROR    = err_q;

endmodule

// File: tb/tb_si570_write_sequencer.sv
// Directed bench for si570_write_sequencer: scripted I2C responder plus
// per-scenario tasks comparing against hand-written expectations.
module tb_si570_write_sequencer;

  localparam int unsigned SET = 20;
  localparam int unsigned TO  = 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] fsel;
  logic       req;
  logic [6:0] addr;
  logic [7:0] i2c_reg, i2c_dat;
  logic       ack, err;
  logic       busy, done, error;

  si570_write_sequencer #(
    .I2C_DEV_ADDR  (7'h55),
    .SETTLE_CYCLES (SET),
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (8)
  ) dut (
    .iCLK     (clk),
    .iRST_n   (rst_n),
    .iSTART   (start),
    .iFREQ_SEL(fsel),
    .oI2C_REQ (req),
    .oI2C_ADDR(addr),
    .oI2C_REG (i2c_reg),
    .oI2C_DATA(i2c_dat),
    .iI2C_ACK (ack),
    .iI2C_ERR (err),
    .oBUSY    (busy),
    .oDONE    (done),
    .oERROR   (error)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Hand-entered register 7..12 bytes for each frequency entry.
  logic [7:0] tbl [4][6] = '{
    '{8'h01, 8'hC2, 8'hBC, 8'h01, 8'h1E, 8'hB8},
    '{8'hE0, 8'h42, 8'hB0, 8'h2B, 8'h1B, 8'h54},
    '{8'h22, 8'h42, 8'hD6, 8'h8A, 8'hB7, 8'h5F},
    '{8'h61, 8'hC2, 8'hA8, 8'h74, 8'h8F, 8'hE6}
  };

  function automatic logic [7:0] exp_reg(input int k);
    if (k == 0 || k == 7) return 8'd137;
    if (k == 8)           return 8'd135;
    return 8'(6 + k);
  endfunction

  function automatic logic [7:0] exp_dat(input int s, input int k);
    if (k == 0) return 8'h10;
    if (k == 7) return 8'h00;
    if (k == 8) return 8'h40;
    return tbl[s][k-1];
  endfunction

  // Responder configuration, written only by the main sequence.
  int resp_delay = 5;
  int err_at     = -1;
  int both_at    = -1;
  int silent_at  = -1;

  // Responder / monitor state, written only by the responder process.
  int          wr_num = 0;
  logic [7:0]  log_reg[$];
  logic [7:0]  log_dat[$];
  int unsigned log_cyc[$];
  int          log_len[$];
  int unsigned last_resp_edge = 0;
  int          done_cnt = 0;
  int          unstable = 0;

  initial begin : responder
    bit         pend;
    int         rcnt, run, cur;
    logic [7:0] hreg, hdat;
    pend = 0; rcnt = 0; run = 0; cur = 0; hreg = '0; hdat = '0;
    ack = 1'b0;
    err = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (rst_n !== 1'b1) begin
        ack = 1'b0; err = 1'b0; pend = 0;
      end else begin
        ack = 1'b0; err = 1'b0;
        if (!req && pend) begin
          log_len.push_back(run);
          pend = 0;
        end
        if (req && !pend) begin
          pend = 1; rcnt = 0; run = 0; cur = wr_num; wr_num++;
          hreg = i2c_reg; hdat = i2c_dat;
          log_reg.push_back(i2c_reg);
          log_dat.push_back(i2c_dat);
          log_cyc.push_back(cyc);
        end
        if (pend) begin
          run++; rcnt++;
          if (i2c_reg !== hreg || i2c_dat !== hdat) unstable++;
          if (rcnt == resp_delay && cur != silent_at) begin
            if (cur == both_at)     begin ack = 1'b1; err = 1'b1; end
            else if (cur == err_at) err = 1'b1;
            else                    ack = 1'b1;
            last_resp_edge = cyc + 1;
          end
        end
      end
    end
  end

  int          vec  = 0;
  int          miss = 0;
  int unsigned start_cyc = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] s);
    tick();
    start = 1'b1;
    fsel  = s;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    vec++; if (req !== 1'b0)      begin miss++; $display("FAIL reset_req got %b want 0", req); end
    vec++; if (addr !== 7'h55)    begin miss++; $display("FAIL reset_addr got %h want 55", addr); end
    vec++; if (i2c_reg !== 8'h00) begin miss++; $display("FAIL reset_reg got %h want 00", i2c_reg); end
    vec++; if (i2c_dat !== 8'h00) begin miss++; $display("FAIL reset_data got %h want 00", i2c_dat); end
    vec++; if ({busy, done, error} !== 3'b000) begin
      miss++; $display("FAIL reset_status got %b want 000", {busy, done, error});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    int base, gaps;
    bit seen;
    logic busy_at_done;
    int unsigned dcyc;
    base = wr_num; gaps = 0; seen = 0; busy_at_done = 1'b1; dcyc = 0;
    pulse_start(2'd2);
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (done === 1'b1) begin seen = 1; busy_at_done = busy; dcyc = cyc; end
      else if (busy !== 1'b1) gaps++;
    end
    vec++; if (!seen) begin miss++; $display("FAIL nom_done_seen got 0 want 1"); end
    vec++; if (gaps != 0) begin miss++; $display("FAIL nom_busy_gaps got %0d want 0", gaps); end
    vec++; if (busy_at_done !== 1'b0) begin miss++; $display("FAIL nom_busy_at_done got %b want 0", busy_at_done); end
    vec++; if (dcyc - last_resp_edge != SET) begin
      miss++; $display("FAIL nom_settle_delay got %0d want %0d", dcyc - last_resp_edge, SET);
    end
    tick();
    vec++; if (done !== 1'b0) begin miss++; $display("FAIL nom_done_width got %b want 0", done); end
    vec++; if (wr_num - base != 9) begin miss++; $display("FAIL nom_write_count got %0d want 9", wr_num - base); end
    for (int k = 0; k < 9 && base + k < wr_num; k++) begin
      vec++;
      if (log_reg[base+k] !== exp_reg(k) || log_dat[base+k] !== exp_dat(2, k)) begin
        miss++;
        $display("FAIL nom_write%0d got %0d/%h want %0d/%h", k, log_reg[base+k], log_dat[base+k],
                 exp_reg(k), exp_dat(2, k));
      end
    end
    if (wr_num - base >= 2) begin
      vec++; if (log_cyc[base] - start_cyc != 2) begin
        miss++; $display("FAIL nom_first_req_latency got %0d want 2", log_cyc[base] - start_cyc);
      end
      vec++; if (log_cyc[base+1] - log_cyc[base] != 6) begin
        miss++; $display("FAIL nom_req_spacing got %0d want 6", log_cyc[base+1] - log_cyc[base]);
      end
    end
    vec++; if (error !== 1'b0) begin miss++; $display("FAIL nom_error got %b want 0", error); end
    vec++; if (unstable != 0) begin miss++; $display("FAIL nom_req_stable got %0d want 0", unstable); end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      if (busy === 1'b0) ok = 1;
    end
  endtask

  task automatic test_nack();
    int base, d0;
    bit ok;
    base = wr_num; d0 = done_cnt;
    err_at = base + 3;
    pulse_start(2'd0);
    wait_idle(ok);
    err_at = -1;
    repeat (10) tick();
    vec++; if (!ok) begin miss++; $display("FAIL nack_idle got busy want idle"); end
    vec++; if (wr_num - base != 5) begin miss++; $display("FAIL nack_write_count got %0d want 5", wr_num - base); end
    if (wr_num - base >= 5) begin
      vec++; if (log_reg[base+3] !== 8'd9 || log_dat[base+3] !== tbl[0][2]) begin
        miss++; $display("FAIL nack_nacked_write got %0d/%h want 9/%h", log_reg[base+3], log_dat[base+3], tbl[0][2]);
      end
      vec++; if (log_reg[base+4] !== 8'd137 || log_dat[base+4] !== 8'h00) begin
        miss++; $display("FAIL nack_recover_write got %0d/%h want 137/00", log_reg[base+4], log_dat[base+4]);
      end
    end
    vec++; if (error !== 1'b1) begin miss++; $display("FAIL nack_error got %b want 1", error); end
    vec++; if (done_cnt != d0) begin miss++; $display("FAIL nack_no_done got %0d want 0", done_cnt - d0); end
  endtask

  task automatic test_timeout();
    int base;
    bit ok;
    base = wr_num;
    silent_at = base;
    pulse_start(2'd3);
    wait_idle(ok);
    repeat (50) tick();
    silent_at = -1;
    vec++; if (!ok) begin miss++; $display("FAIL to_idle got busy want idle"); end
    vec++; if (wr_num - base != 1) begin miss++; $display("FAIL to_write_count got %0d want 1", wr_num - base); end
    if (log_len.size() > base) begin
      vec++; if (log_len[base] != TO) begin miss++; $display("FAIL to_req_len got %0d want %0d", log_len[base], TO); end
    end
    vec++; if (error !== 1'b1 || req !== 1'b0) begin
      miss++; $display("FAIL to_status got err=%b req=%b want err=1 req=0", error, req);
    end
  endtask

  task automatic test_ignored_start();
    int base;
    bit seen;
    base = wr_num; seen = 0;
    pulse_start(2'd1);
    tick();
    vec++; if (error !== 1'b0) begin miss++; $display("FAIL ign_error_cleared got %b want 0", error); end
    for (int i = 0; i < 100 && wr_num < base + 3; i++) tick();
    pulse_start(2'd3);
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (done === 1'b1) seen = 1;
    end
    repeat (3) tick();
    vec++; if (!seen) begin miss++; $display("FAIL ign_done_seen got 0 want 1"); end
    vec++; if (wr_num - base != 9) begin miss++; $display("FAIL ign_write_count got %0d want 9", wr_num - base); end
    for (int k = 0; k < 9 && base + k < wr_num; k++) begin
      vec++;
      if (log_reg[base+k] !== exp_reg(k) || log_dat[base+k] !== exp_dat(1, k)) begin
        miss++;
        $display("FAIL ign_write%0d got %0d/%h want %0d/%h", k, log_reg[base+k], log_dat[base+k],
                 exp_reg(k), exp_dat(1, k));
      end
    end
  endtask

  task automatic test_ack_err_same();
    int base, d0;
    bit ok;
    base = wr_num; d0 = done_cnt;
    both_at = base + 7;
    pulse_start(2'd2);
    wait_idle(ok);
    both_at = -1;
    repeat (10) tick();
    vec++; if (!ok) begin miss++; $display("FAIL both_idle got busy want idle"); end
    vec++; if (wr_num - base != 9) begin miss++; $display("FAIL both_write_count got %0d want 9", wr_num - base); end
    if (wr_num - base >= 9) begin
      vec++; if (log_reg[base+8] !== 8'd137 || log_dat[base+8] !== 8'h00) begin
        miss++; $display("FAIL both_recover_write got %0d/%h want 137/00", log_reg[base+8], log_dat[base+8]);
      end
    end
    vec++; if (error !== 1'b1) begin miss++; $display("FAIL both_error got %b want 1", error); end
    vec++; if (done_cnt != d0) begin miss++; $display("FAIL both_no_done got %0d want 0", done_cnt - d0); end
  endtask

  task automatic test_reset_in_settle();
    int base;
    bit seen;
    base = wr_num; seen = 0;
    pulse_start(2'd0);
    for (int i = 0; i < 200 && !(wr_num == base + 9 && req === 1'b0); i++) tick();
    repeat (5) tick();
    vec++; if (busy !== 1'b1 || i2c_reg !== 8'd135) begin
      miss++; $display("FAIL rst_in_settle got busy=%b reg=%0d want busy=1 reg=135", busy, i2c_reg);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vec++; if ({req, busy, done, error} !== 4'b0000 || addr !== 7'h55 || i2c_reg !== 8'h00 || i2c_dat !== 8'h00) begin
      miss++;
      $display("FAIL rst_async got req=%b busy=%b done=%b err=%b addr=%h reg=%h dat=%h want 0 0 0 0 55 00 00",
               req, busy, done, error, addr, i2c_reg, i2c_dat);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    base = wr_num;
    pulse_start(2'd3);
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (done === 1'b1) seen = 1;
    end
    repeat (3) tick();
    vec++; if (!seen || wr_num - base != 9) begin
      miss++; $display("FAIL rst_rerun got done=%0d writes=%0d want 1 9", seen, wr_num - base);
    end
    for (int k = 0; k < 9 && base + k < wr_num; k++) begin
      vec++;
      if (log_reg[base+k] !== exp_reg(k) || log_dat[base+k] !== exp_dat(3, k)) begin
        miss++;
        $display("FAIL rst_rerun_write%0d got %0d/%h want %0d/%h", k, log_reg[base+k], log_dat[base+k],
                 exp_reg(k), exp_dat(3, k));
      end
    end
    vec++; if (error !== 1'b0) begin miss++; $display("FAIL rst_rerun_error got %b want 0", error); end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fsel  = 2'd0;
    test_reset();
    test_nominal();
    test_nack();
    test_timeout();
    test_ignored_start();
    test_ack_err_same();
    test_reset_in_settle();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
